// File: rtl/fpu_cmd_issuer_if.sv
// +--------------------------------------------------------------------------+
// | fpu_cmd_if / fpu_core_if : CPU command/response and FPU_Core channels    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface fpu_cmd_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_inst;
   logic [2:0]  cmd_stack_index;
   logic [79:0] cmd_data;
   logic [31:0] cmd_int_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_inst;
   logic [79:0] rsp_data;
   logic [15:0] rsp_status;
   logic        rsp_error;
   logic        rsp_timeout;

   modport master (
      output cmd_valid, cmd_inst, cmd_stack_index, cmd_data, cmd_int_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_inst, rsp_data, rsp_status, rsp_error, rsp_timeout
   );
   modport slave (
      input  cmd_valid, cmd_inst, cmd_stack_index, cmd_data, cmd_int_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_inst, rsp_data, rsp_status, rsp_error, rsp_timeout
   );
endinterface

interface fpu_core_if;
   logic        fpu_execute;
   logic [7:0]  fpu_instruction;
   logic [2:0]  fpu_stack_index;
   logic [79:0] fpu_data_in;
   logic [31:0] fpu_int_data_in;
   logic        fpu_ready;
   logic        fpu_error;
   logic [79:0] fpu_data_out;
   logic [15:0] fpu_status_out;

   modport master (
      output fpu_execute, fpu_instruction, fpu_stack_index, fpu_data_in, fpu_int_data_in,
      input  fpu_ready, fpu_error, fpu_data_out, fpu_status_out
   );
   modport slave (
      input  fpu_execute, fpu_instruction, fpu_stack_index, fpu_data_in, fpu_int_data_in,
      output fpu_ready, fpu_error, fpu_data_out, fpu_status_out
   );
endinterface

`default_nettype wire

// File: rtl/fpu_cmd_issuer.sv
// +--------------------------------------------------------------------------+
// | fpu_cmd_issuer : FIFO-buffered execute/ready initiator for FPU_Core      |
// | Optional watchdog: define FPU_ISSUER_TIMEOUT_EN          Revision: 1.0   |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fpu_cmd_issuer #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int CNT_W          = 14
) (
   input  logic       clk,
   input  logic       reset,
   fpu_cmd_if.slave   cmd_if,
   fpu_core_if.master core_if,
   output logic       busy
);

   localparam int             PTR_W    = $clog2(FIFO_DEPTH);
   localparam int             ENTRY_W  = 8 + 3 + 80 + 32;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       (2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
      $error("fpu_cmd_issuer: illegal FIFO_DEPTH / CNT_W / TIMEOUT_CYCLES");
   end

   logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [PTR_W:0]     count_q;
   logic [PTR_W:0]     count_d;
   logic               cmd_ready_q;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] head;

   logic [2:0]         state_q;
   logic [2:0]         state_d;
   logic               capture;

   logic [7:0]         inst_q;
   logic [2:0]         idx_q;
   logic [79:0]        data_q;
   logic [31:0]        int_q;

   logic [7:0]         rsp_inst_q;
   logic [79:0]        rsp_data_q;
   logic [15:0]        rsp_status_q;
   logic               rsp_error_q;

   assign push = cmd_if.cmd_valid & cmd_ready_q;
   assign head = fifo_mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {cmd_if.cmd_inst, cmd_if.cmd_stack_index,
                                  cmd_if.cmd_data, cmd_if.cmd_int_data};
      end
   end

   // Ready is registered from the next count so it is low out of reset and drops the cycle the FIFO fills.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q     <= count_d;
         cmd_ready_q <= (count_d != FULL_CNT);
      end
   end

`ifdef FPU_ISSUER_TIMEOUT_EN
   localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] WDOG_ONE   = CNT_W'(1);

   logic [CNT_W-1:0] wdog_q;
   logic             expire;
   logic             rsp_timeout_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_q <= '0;
      end else if (state_q == S_SETTLE) begin
         wdog_q <= '0;
      end else if (state_q == S_WAIT && !core_if.fpu_ready) begin
         wdog_q <= wdog_q + WDOG_ONE;
      end
   end

   assign cmd_if.rsp_timeout = rsp_timeout_q;
`else
   assign cmd_if.rsp_timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      capture = 1'b0;
`ifdef FPU_ISSUER_TIMEOUT_EN
      expire  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE:  state_d = S_SETTLE;
         // FPU_Core may still show ready from the previous command here.
         S_SETTLE: state_d = S_WAIT;
         S_WAIT: begin
            if (core_if.fpu_ready) begin
               capture = 1'b1;
               state_d = S_RESP;
            end
`ifdef FPU_ISSUER_TIMEOUT_EN
            else if (wdog_q == WDOG_LIMIT) begin
               expire  = 1'b1;
               state_d = S_RESP;
            end
`endif
         end
         S_RESP: begin
            if (cmd_if.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inst_q <= '0;
         idx_q  <= '0;
         data_q <= '0;
         int_q  <= '0;
      end else if (pop) begin
         {inst_q, idx_q, data_q, int_q} <= head;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_inst_q    <= '0;
         rsp_data_q    <= '0;
         rsp_status_q  <= '0;
         rsp_error_q   <= 1'b0;
`ifdef FPU_ISSUER_TIMEOUT_EN
         rsp_timeout_q <= 1'b0;
`endif
      end else if (capture) begin
         rsp_inst_q    <= inst_q;
         rsp_data_q    <= core_if.fpu_data_out;
         rsp_status_q  <= core_if.fpu_status_out;
         rsp_error_q   <= core_if.fpu_error;
`ifdef FPU_ISSUER_TIMEOUT_EN
         rsp_timeout_q <= 1'b0;
      end else if (expire) begin
         rsp_inst_q    <= inst_q;
         rsp_data_q    <= '0;
         rsp_status_q  <= core_if.fpu_status_out;
         rsp_error_q   <= 1'b1;
         rsp_timeout_q <= 1'b1;
`endif
      end
   end

   assign cmd_if.cmd_ready  = cmd_ready_q;
   assign cmd_if.rsp_valid  = (state_q == S_RESP);
   assign cmd_if.rsp_inst   = rsp_inst_q;
   assign cmd_if.rsp_data   = rsp_data_q;
   assign cmd_if.rsp_status = rsp_status_q;
   assign cmd_if.rsp_error  = rsp_error_q;

   assign core_if.fpu_execute     = (state_q == S_ISSUE);
   assign core_if.fpu_instruction = inst_q;
   assign core_if.fpu_stack_index = idx_q;
   assign core_if.fpu_data_in     = data_q;
   assign core_if.fpu_int_data_in = int_q;

   assign busy = (state_q != S_IDLE) || (count_q != '0);

endmodule

`default_nettype wire
